// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core with one shared instruction/data memory port.
// Each instruction walks FETCH -> DECODE -> class-specific states and back to FETCH.
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] MemReadData,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemRead,
    output logic        MemWrite
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        R_EXEC,
        R_WB,
        I_EXEC,
        I_WB,
        ADDR,
        LW_READ,
        LW_WB,
        SW_WRITE,
        BRANCH,
        JUMP,
        JR
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic [31:0] regs [32];

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] jump_target;
    logic [31:0] alu_r;
    logic [31:0] alu_i;
    logic        branch_taken;

    assign op          = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign funct       = ir[5:0];
    assign imm_sext    = {{16{ir[15]}}, ir[15:0]};
    assign imm_zext    = {16'h0000, ir[15:0]};
    assign rs_val      = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val      = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign jump_target = {pc[31:28], ir[25:0], 2'b00};
    assign branch_taken = ((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b));

    // Register-register ALU, selected by funct
    always_comb begin
        alu_r = 32'd0;
        case (funct)
            FN_ADD:  alu_r = a + b;
            FN_SUB:  alu_r = a - b;
            FN_AND:  alu_r = a & b;
            FN_OR:   alu_r = a | b;
            FN_SLT:  alu_r = {31'd0, $signed(a) < $signed(b)};
            default: alu_r = 32'd0;
        endcase
    end

    // Register-immediate ALU; logical ops zero-extend, arithmetic ops sign-extend
    always_comb begin
        alu_i = 32'd0;
        case (op)
            OP_ADDI: alu_i = a + imm_sext;
            OP_SLTI: alu_i = {31'd0, $signed(a) < $signed(imm_sext)};
            OP_ANDI: alu_i = a & imm_zext;
            OP_ORI:  alu_i = a | imm_zext;
            default: alu_i = 32'd0;
        endcase
    end

    function automatic state_t dispatch(input logic [5:0] opc, input logic [5:0] fn);
        state_t nxt;
        nxt = FETCH;
        case (opc)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = R_EXEC;
                    FN_JR:   nxt = JR;
                    default: nxt = FETCH;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = I_EXEC;
            OP_LW, OP_SW:   nxt = ADDR;
            OP_BEQ, OP_BNE: nxt = BRANCH;
            OP_J, OP_JAL:   nxt = JUMP;
            default:        nxt = FETCH;
        endcase
        return nxt;
    endfunction

    // Memory port strobes are Moore outputs, forced idle while reset is asserted
    always_comb begin
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemAddress   = pc;
        MemWriteData = 32'd0;
        if (Rst) begin
            case (state)
                FETCH: MemRead = 1'b1;
                LW_READ: begin
                    MemRead    = 1'b1;
                    MemAddress = alu_out;
                end
                SW_WRITE: begin
                    MemWrite     = 1'b1;
                    MemAddress   = alu_out;
                    MemWriteData = b;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            alu_out <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            case (state)
                FETCH: begin
                    ir    <= MemReadData;
                    pc    <= pc + 32'd4;
                    state <= DECODE;
                end
                DECODE: begin
                    a       <= rs_val;
                    b       <= rt_val;
                    alu_out <= pc + {imm_sext[29:0], 2'b00};
                    state   <= dispatch(op, funct);
                end
                R_EXEC: begin
                    alu_out <= alu_r;
                    state   <= R_WB;
                end
                R_WB: begin
                    if (rd != 5'd0) regs[rd] <= alu_out;
                    state <= FETCH;
                end
                I_EXEC: begin
                    alu_out <= alu_i;
                    state   <= I_WB;
                end
                I_WB: begin
                    if (rt != 5'd0) regs[rt] <= alu_out;
                    state <= FETCH;
                end
                ADDR: begin
                    alu_out <= a + imm_sext;
                    state   <= (op == OP_LW) ? LW_READ : SW_WRITE;
                end
                LW_READ: begin
                    mdr   <= MemReadData;
                    state <= LW_WB;
                end
                LW_WB: begin
                    if (rt != 5'd0) regs[rt] <= mdr;
                    state <= FETCH;
                end
                SW_WRITE: state <= FETCH;
                BRANCH: begin
                    if (branch_taken) pc <= alu_out;
                    state <= FETCH;
                end
                // pc already holds the return address (fetch address + 4)
                JUMP: begin
                    pc <= jump_target;
                    if (op == OP_JAL) regs[31] <= pc;
                    state <= FETCH;
                end
                JR: begin
                    pc    <= a;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: directed program plus random straight-line code, checked
// cycle by cycle against an instruction-level reference interpreter.
module tb_mc_cpu_core;

    localparam logic [31:0] NOP_WORD  = 32'hFC00_0000;
    localparam int          RAND_BASE = 128;
    localparam int          RAND_N    = 160;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] mem_rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        we;
    logic        load_en;

    logic [31:0] mem     [1024];
    logic [31:0] img     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] m_regs  [32];
    logic [31:0] m_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    mc_cpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .MemReadData  (mem_rdata),
        .MemAddress   (addr),
        .MemWriteData (wdata),
        .MemRead      (rd),
        .MemWrite     (we)
    );

    // Word memory: combinational read, write on the rising edge, bulk image load
    assign mem_rdata = mem[addr[11:2]];
    always @(posedge Clk) begin
        if (load_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= img[i];
        end else if (we) begin
            mem[addr[11:2]] <= wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs_i, input int rt_i, input int rd_i, input int fn);
        return {6'h00, 5'(rs_i), 5'(rt_i), 5'(rd_i), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int opc, input int rs_i, input int rt_i, input int imm);
        return {6'(opc), 5'(rs_i), 5'(rt_i), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int opc, input int target);
        return {6'(opc), 26'(target)};
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = img[i];
    endtask

    // Execute one instruction in the model while following the DUT cycle by cycle.
    // Entered at the falling edge of the fetch cycle; leaves at the next fetch.
    task automatic run_one();
        logic [31:0] ir, simm, zimm, ra, rb, nxt, wr_val, mem_addr;
        logic [5:0]  opc, fn;
        logic [4:0]  wr_reg;
        int          cpi;
        bit          do_wr, is_lw, is_sw;
        check_eq("fetch_rd", 32'(rd), 32'd1);
        check_eq($sformatf("fetch_pc@%0h", m_pc), addr, m_pc);
        check_eq("fetch_we", 32'(we), 32'd0);
        ir   = ref_mem[m_pc[11:2]];
        opc  = ir[31:26];
        fn   = ir[5:0];
        simm = {{16{ir[15]}}, ir[15:0]};
        zimm = {16'h0000, ir[15:0]};
        ra   = m_regs[ir[25:21]];
        rb   = m_regs[ir[20:16]];
        nxt  = m_pc + 32'd4;
        cpi  = 2;
        do_wr = 0; is_lw = 0; is_sw = 0;
        wr_reg = ir[20:16];
        wr_val = 32'd0;
        mem_addr = ra + simm;
        case (opc)
            6'h00: begin
                wr_reg = ir[15:11];
                cpi = 4; do_wr = 1;
                case (fn)
                    6'h20: wr_val = ra + rb;
                    6'h22: wr_val = ra - rb;
                    6'h24: wr_val = ra & rb;
                    6'h25: wr_val = ra | rb;
                    6'h2A: wr_val = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
                    6'h08: begin cpi = 3; do_wr = 0; nxt = ra; end
                    default: begin cpi = 2; do_wr = 0; end
                endcase
            end
            6'h08: begin cpi = 4; do_wr = 1; wr_val = ra + simm; end
            6'h0A: begin cpi = 4; do_wr = 1; wr_val = ($signed(ra) < $signed(simm)) ? 32'd1 : 32'd0; end
            6'h0C: begin cpi = 4; do_wr = 1; wr_val = ra & zimm; end
            6'h0D: begin cpi = 4; do_wr = 1; wr_val = ra | zimm; end
            6'h23: begin cpi = 5; do_wr = 1; is_lw = 1; wr_val = ref_mem[mem_addr[11:2]]; end
            6'h2B: begin cpi = 4; is_sw = 1; end
            6'h04: begin cpi = 3; if (ra == rb) nxt = m_pc + 32'd4 + (simm << 2); end
            6'h05: begin cpi = 3; if (ra != rb) nxt = m_pc + 32'd4 + (simm << 2); end
            6'h02: begin cpi = 3; nxt = {nxt[31:28], ir[25:0], 2'b00}; end
            6'h03: begin
                cpi = 3; do_wr = 1; wr_reg = 5'd31; wr_val = m_pc + 32'd4;
                nxt = {nxt[31:28], ir[25:0], 2'b00};
            end
            default: cpi = 2;
        endcase
        for (int c = 1; c < cpi; c++) begin
            @(negedge Clk);
            check_eq($sformatf("we@%0h.%0d", m_pc, c), 32'(we), 32'(is_sw && c == 3));
            check_eq($sformatf("rd@%0h.%0d", m_pc, c), 32'(rd), 32'(is_lw && c == 3));
            if (c == 3 && (is_sw || is_lw)) check_eq($sformatf("maddr@%0h", m_pc), addr, mem_addr);
            if (c == 3 && is_sw) check_eq($sformatf("wdata@%0h", m_pc), wdata, rb);
        end
        if (is_sw) ref_mem[mem_addr[11:2]] = rb;
        if (do_wr && wr_reg != 5'd0) m_regs[wr_reg] = wr_val;
        m_pc = nxt;
        @(negedge Clk);
    endtask

    function automatic logic [31:0] rand_instr();
        int k, r1, r2;
        int fns[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        int iops[4] = '{32'h08, 32'h0A, 32'h0C, 32'h0D};
        k  = int'($urandom_range(0, 11));
        r1 = int'($urandom_range(0, 7));
        r2 = ($urandom_range(0, 1) == 0) ? r1 : int'($urandom_range(0, 7));
        case (k)
            0, 1, 2:   return enc_r(r1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                    fns[$urandom_range(0, 4)]);
            3, 4, 10, 11: return enc_i(iops[$urandom_range(0, 3)], r1, int'($urandom_range(0, 7)),
                                       int'($urandom_range(0, 65535)));
            5:  return enc_i(32'h23, 0, int'($urandom_range(1, 7)), int'($urandom_range(512, 1023)) * 4
                             + int'($urandom_range(0, 3)));
            6:  return enc_i(32'h2B, 0, r1, int'($urandom_range(512, 1023)) * 4);
            7:  return enc_i(32'h04, r1, r2, int'($urandom_range(0, 3)));
            8:  return enc_i(32'h05, r1, r2, int'($urandom_range(0, 3)));
            default: return ($urandom_range(0, 1) == 0) ? NOP_WORD : enc_r(r1, r2, 3, 0);
        endcase
    endfunction

    initial begin
        int steps;
        logic [31:0] exp_dir [32];
        int bad_words;

        // Directed program followed by random code at 0x200 and random data at 0x800+
        for (int i = 0; i < 1024; i++) img[i] = (i >= 512) ? $urandom : NOP_WORD;
        img[0]  = NOP_WORD;
        img[1]  = enc_i(8, 0, 1, 5);
        img[2]  = enc_i(8, 0, 2, -3);
        img[3]  = enc_r(1, 2, 3, 32'h20);
        img[4]  = enc_r(1, 2, 4, 32'h22);
        img[5]  = enc_r(2, 1, 5, 32'h2A);
        img[6]  = enc_i(32'h0D, 0, 6, 32'hFFFF);
        img[7]  = enc_i(32'h2B, 0, 3, 100);
        img[8]  = enc_i(4, 1, 1, 2);
        img[9]  = enc_i(8, 0, 9, 1);
        img[10] = enc_i(8, 0, 9, 1);
        img[11] = enc_i(32'h23, 0, 7, 100);
        img[12] = enc_j(3, 32'h40);
        img[13] = enc_i(8, 0, 0, 7);
        img[14] = enc_i(5, 1, 1, 2);
        img[15] = enc_j(2, 32'h80);
        img[64] = enc_r(31, 0, 0, 32'h08);
        for (int i = 0; i < RAND_N; i++) img[RAND_BASE + i] = rand_instr();

        Rst = 1'b0;
        load_en = 1'b1;
        @(posedge Clk);
        #1 load_en = 1'b0;
        @(negedge Clk);
        check_eq("rst_rd", 32'(rd), 32'd0);
        check_eq("rst_we", 32'(we), 32'd0);
        check_eq("rst_wdata", wdata, 32'd0);
        check_eq("rst_addr", addr, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        model_reset();

        steps = 0;
        while (m_pc != 32'h200 && steps < 100 && n_errors < 40) begin
            run_one();
            steps++;
        end
        check_eq("dir_reached_0x200", m_pc, 32'h200);

        for (int i = 0; i < 32; i++) exp_dir[i] = 32'd0;
        exp_dir[1] = 32'd5; exp_dir[2] = 32'hFFFF_FFFD; exp_dir[3] = 32'd2;
        exp_dir[4] = 32'd8; exp_dir[5] = 32'd1; exp_dir[6] = 32'h0000_FFFF;
        exp_dir[7] = 32'd2; exp_dir[31] = 32'h34;
        foreach (exp_dir[i]) check_eq($sformatf("dir_r%0d", i), dut.regs[i], exp_dir[i]);
        check_eq("dir_mem100", mem[25], 32'd2);

        steps = 0;
        while (m_pc >= 32'h200 && m_pc < 32'(4 * (RAND_BASE + RAND_N))
               && steps < 2000 && n_errors < 40) begin
            run_one();
            steps++;
        end
        for (int i = 0; i < 32; i++) check_eq($sformatf("rnd_r%0d", i), dut.regs[i], m_regs[i]);
        bad_words = 0;
        for (int i = 512; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        check_eq("rnd_dmem_bad_words", 32'(bad_words), 32'd0);

        // Reset asserted in the SW_WRITE cycle must drop the store
        for (int i = 0; i < 1024; i++) img[i] = NOP_WORD;
        img[0]     = enc_i(8, 0, 1, 32'h55);
        img[1]     = enc_i(32'h2B, 0, 1, 32'h900);
        img[32'h240] = 32'hDEAD_BEEF;
        Rst = 1'b0;
        load_en = 1'b1;
        @(posedge Clk);
        #1 load_en = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        model_reset();
        run_one();
        check_eq("sw_fetch_addr", addr, 32'd4);
        repeat (3) @(negedge Clk);
        check_eq("sw_we_pre", 32'(we), 32'd1);
        check_eq("sw_addr_pre", addr, 32'h900);
        check_eq("sw_data_pre", wdata, 32'h55);
        Rst = 1'b0;
        #1;
        check_eq("sw_we_in_rst", 32'(we), 32'd0);
        @(negedge Clk);
        check_eq("sw_mem_kept", mem[32'h240], 32'hDEAD_BEEF);
        check_eq("sw_rst_addr", addr, 32'd0);
        Rst = 1'b1;
        #1;
        check_eq("post_rst_rd", 32'(rd), 32'd1);
        check_eq("post_rst_addr", addr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
- 32-bit multi-cycle MIPS-subset processor core with one shared instruction/data memory port (von Neumann).
- Fetch, decode, execute, memory and write-back run as separate clock cycles of an internal FSM.
- Sits between the system clock/reset and the external word memory, which has combinational read and synchronous write.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  reset, synchronous, active-low.
- MemReadData  input  32  memory read data; combinational from MemAddress.
- MemAddress  output  32  byte address; memory uses Address[31:2].
- MemWriteData  output  32  store data.
- MemRead  output  1  read strobe.
- MemWrite  output  1  write strobe; memory writes on the rising edge while high.

Behaviour:
- Reset (Rst==0 at a rising edge):
  - PC<=RESET_PC; FSM<=FETCH; IR, MDR, A, B, ALUOut and all 32 registers cleared.
  - While Rst low: MemRead=0, MemWrite=0, MemAddress=PC, MemWriteData=0.
  - Reset mid-instruction aborts it; any write strobed in that cycle is suppressed.
- Register file:
  - 32x32, two combinational reads, one write on the rising edge.
  - $0 reads 0 and ignores writes.
- Outputs are Moore, decoded from FSM state.
- FSM states and actions:
  - FETCH: MemRead=1, MemAddress=PC; IR<=MemReadData; PC<=PC+4.
  - DECODE: A<=R[rs]; B<=R[rt]; ALUOut<=PC+(sext(imm)<<2). Dispatch on opcode/funct.
  - R_EXEC: ALUOut<=A op B -> R_WB.
  - R_WB: R[rd]<=ALUOut -> FETCH.
  - I_EXEC: ALUOut<=A op imm. addi/slti sign-extend imm; andi/ori zero-extend -> I_WB.
  - I_WB: R[rt]<=ALUOut -> FETCH.
  - ADDR: ALUOut<=A+sext(imm) -> LW_READ (lw) or SW_WRITE (sw).
  - LW_READ: MemRead=1, MemAddress=ALUOut; MDR<=MemReadData -> LW_WB.
  - LW_WB: R[rt]<=MDR -> FETCH.
  - SW_WRITE: MemWrite=1, MemAddress=ALUOut, MemWriteData=B -> FETCH.
  - BRANCH: if beq and A==B, or bne and A!=B, PC<=ALUOut -> FETCH.
  - JUMP: PC<={PC[31:28], IR[25:0], 2'b00}; for jal also R[31]<=PC (already PC+4) -> FETCH.
  - JR: PC<=A -> FETCH.
- Encodings:
  - R-type (opcode 0x00) by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), jr 0x08.
  - I/J by opcode: addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
  - Any other opcode/funct is a NOP: DECODE -> FETCH.
- Cycles per instruction:
  - 5: lw.
  - 4: R-type, I-ALU, sw.
  - 3: beq/bne, j, jal, jr.
  - 2: NOP.
- Arithmetic: 32-bit two's-complement, wrap-around, no overflow traps. slt/slti write 1 or 0.
- Alignment: low two address bits are ignored by memory; no alignment checks.
- Memory contract: a read returns the word last written. A write in SW_WRITE is visible to the FETCH in the next cycle.

Test Plan:
- Reset: hold Rst=0 for 2 cycles, then release.
  - -> first cycle after release: MemRead=1, MemAddress=0.
  - -> next fetch at address 4, two cycles later (instruction at 0 is a NOP).
- ALU: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1; ori $6,$0,0xFFFF.
  - -> $3=2, $4=8, $5=1, $6=0x0000FFFF.
  - -> add occupies exactly 4 cycles between fetches.
- Memory: sw $3,100($0), then lw $7,100($0).
  - -> MemWrite pulses one cycle with MemAddress=100, MemWriteData=2.
  - -> $7=2; lw takes 5 cycles.
- Branches: beq $1,$1,+2 at PC=0x20.
  - -> next fetch 0x2C.
  - -> bne $1,$1,+2 instead: next fetch 0x24.
  - -> 3 cycles each.
- Jumps:
  - jal 0x40 at PC=0x30 -> $31=0x34, next fetch 0x100.
  - jr $31 -> next fetch 0x34.
  - addi $0,$0,7 -> $0 still 0.
- Reset during SW_WRITE cycle -> no memory write; next fetch at 0.
